// File: rtl/dmem_bridge.sv
// dmem_bridge: request/acknowledge data-memory bridge that stalls the datapath and flags misaligned or timed-out accesses.
// Defining DMEM_BRIDGE_WRITE_POST_EN adds a one-entry posted-write buffer that drains in the background.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_out,
  input  logic [31:0] dmem_wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        err_misaligned,
  output logic        err_timeout,
  input  logic        err_clear
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] rd_q, rd_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        err_mis_q, err_mis_d;
  logic        err_to_q, err_to_d;
  logic [7:0]  cnt_q, cnt_d;

  logic draining_s, bus_active_s, xfer_done_s, access_s, aligned_s;
  logic set_mis_s, set_to_s;

`ifdef DMEM_BRIDGE_WRITE_POST_EN
  logic drain_q, drain_d;
  assign draining_s = drain_q;
`else
  assign draining_s = 1'b0;
`endif

  assign access_s     = mem_read | mem_write;
  assign aligned_s    = (alu_out[1:0] == 2'b00);
  // The FSM access and a background drain never overlap, so they share one transaction engine.
  assign bus_active_s = (state_q == ACCESS) | draining_s;
  assign xfer_done_s  = bus_active_s & (bus_ack | (cnt_q == TO_LAST));

  // Next-state, datapath stall and error-flag computation.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    set_mis_s   = 1'b0;
    set_to_s    = 1'b0;
`ifdef DMEM_BRIDGE_WRITE_POST_EN
    drain_d     = drain_q;
`endif

    if (bus_active_s) begin
      cnt_d = cnt_q + 8'd1;
      if (bus_ack) begin
        rd_d      = bus_we_q ? rd_q : bus_rdata;
        bus_req_d = 1'b0;
      end else if (cnt_q == TO_LAST) begin
        set_to_s  = 1'b1;
        rd_d      = bus_we_q ? rd_q : ERR_DATA;
        bus_req_d = 1'b0;
      end else begin
        bus_req_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end

`ifdef DMEM_BRIDGE_WRITE_POST_EN
    if (draining_s && xfer_done_s) begin
      drain_d = 1'b0;
    end else begin
      drain_d = drain_q;
    end
`endif

    case (state_q)
      IDLE: begin
        stall = access_s;
        if (access_s && !draining_s) begin
          cnt_d = 8'd0;
          if (!aligned_s) begin
            set_mis_s = 1'b1;
            rd_d      = mem_read ? 32'd0 : rd_q;
            state_d   = DONE;
          end else begin
            // A simultaneous read and write is resolved as a read.
            bus_addr_d  = alu_out[31:2];
            bus_wdata_d = dmem_wd;
            bus_we_d    = ~mem_read;
            bus_req_d   = 1'b1;
`ifdef DMEM_BRIDGE_WRITE_POST_EN
            if (mem_read) begin
              state_d = ACCESS;
            end else begin
              stall   = 1'b0;
              drain_d = 1'b1;
              state_d = IDLE;
            end
`else
            state_d = ACCESS;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        stall   = 1'b1;
        state_d = xfer_done_s ? DONE : ACCESS;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    err_mis_d = set_mis_s | (err_mis_q & ~err_clear);
    err_to_d  = set_to_s | (err_to_q & ~err_clear);
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_q        <= 32'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 30'd0;
      bus_wdata_q <= 32'd0;
      err_mis_q   <= 1'b0;
      err_to_q    <= 1'b0;
      cnt_q       <= 8'd0;
`ifdef DMEM_BRIDGE_WRITE_POST_EN
      drain_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      err_mis_q   <= err_mis_d;
      err_to_q    <= err_to_d;
      cnt_q       <= cnt_d;
`ifdef DMEM_BRIDGE_WRITE_POST_EN
      drain_q     <= drain_d;
`endif
    end
  end

  assign rd             = rd_q;
  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_addr       = bus_addr_q;
  assign bus_wdata      = bus_wdata_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: randomized self-checking bench for dmem_bridge against an instruction-level memory model.
module tb_dmem_bridge;

`ifdef DMEM_BRIDGE_WRITE_POST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, mem_read, mem_write, bus_ack, err_clear;
  logic [31:0] alu_out, dmem_wd, bus_rdata;
  logic [31:0] rd, bus_wdata;
  logic        stall, bus_req, bus_we, err_misaligned, err_timeout;
  logic [29:0] bus_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] bus_mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] exp_rd;
  int          ack_delay = 1;
  bit          resp_en = 1'b1;
  bit          manual_ack = 1'b0;
  int          req_cyc = 0;

  int          mon_reqs = 0;
  int          mon_unstable = 0;
  logic        prev_req = 1'b0;
  logic [29:0] mon_addr = 30'd0;
  logic        mon_we = 1'b0;
  logic [31:0] mon_wdata = 32'd0;

  dmem_bridge dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .alu_out(alu_out), .dmem_wd(dmem_wd), .rd(rd), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .err_misaligned(err_misaligned),
    .err_timeout(err_timeout), .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  // Memory responder: acks after ack_delay request cycles, writes on ack.
  always @(posedge clock) begin
    #2;
    if (manual_ack) begin
      bus_ack   = 1'b1;
      bus_rdata = 32'h5555_AAAA;
    end else if (resp_en && bus_req === 1'b1) begin
      req_cyc++;
      if (req_cyc == ack_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = bus_mem[bus_addr[5:0]];
        if (bus_we) bus_mem[bus_addr[5:0]] = bus_wdata;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end
    end else begin
      bus_ack = 1'b0;
      if (bus_req !== 1'b1) req_cyc = 0;
    end
  end

  // Bus monitor: counts request cycles and stability violations within a burst.
  always @(negedge clock) begin
    if (bus_req === 1'b1) begin
      mon_reqs++;
      if (!prev_req) begin
        mon_addr  = bus_addr;
        mon_we    = bus_we;
        mon_wdata = bus_wdata;
      end else if (bus_addr !== mon_addr || bus_we !== mon_we || bus_wdata !== mon_wdata) begin
        mon_unstable++;
      end
    end
    prev_req = (bus_req === 1'b1);
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present one instruction and hold it until the bridge releases stall; returns stall cycles.
  task automatic do_instr(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    mem_read = r; mem_write = w; alu_out = a; dmem_wd = d;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clock);
      if (stall === 1'b1) begin
        stalls++;
        @(posedge clock);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL instr_wait: stall high for %0d cycles, required release", stalls);
      stalls = -1;
    end
    @(posedge clock);
    #1;
    mem_read = 1'b0; mem_write = 1'b0; alu_out = $urandom; dmem_wd = $urandom;
  endtask

  task automatic test_reset;
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; alu_out = 32'd0; dmem_wd = 32'd0;
    err_clear = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (rd !== 32'd0 || bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 30'd0 || bus_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: rd=%h req=%b we=%b addr=%h wdata=%h, required all zero", rd, bus_req, bus_we, bus_addr, bus_wdata);
    end
    checks++;
    if (err_misaligned !== 1'b0 || err_timeout !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: mis=%b to=%b stall=%b, required 0 0 0", err_misaligned, err_timeout, stall);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_rd = 32'd0;
  endtask

  task automatic test_load_immediate;
    int st, r0;
    ack_delay = 1;
    bus_mem[63] = 32'h1234_5678; ref_mem[63] = 32'h1234_5678;
    r0 = mon_reqs;
    do_instr(1'b1, 1'b0, 32'h0000_00FC, 32'd0, st);
    exp_rd = ref_mem[63];
    checks++;
    if (st !== 2) begin errors++; $display("FAIL load_imm_stall: got %0d, required 2", st); end
    checks++;
    if (mon_addr !== 30'h3F || mon_we !== 1'b0 || mon_reqs - r0 !== 1) begin
      errors++;
      $display("FAIL load_imm_bus: addr=%h we=%b reqs=%0d, required 3f 0 1", mon_addr, mon_we, mon_reqs - r0);
    end
    checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL load_imm_rd: got %h, required 12345678", rd); end
  endtask

  task automatic test_store_delayed;
    int st, r0, u0;
    ack_delay = 3;
    r0 = mon_reqs; u0 = mon_unstable;
    do_instr(1'b0, 1'b1, 32'h0000_0100, 32'hA5A5_0001, st);
    ref_mem[0] = 32'hA5A5_0001;
    idle_cycles(5);
    checks++;
    if (st !== (POSTED ? 0 : 4)) begin errors++; $display("FAIL store_stall: got %0d, required %0d", st, POSTED ? 0 : 4); end
    checks++;
    if (mon_reqs - r0 !== 3 || mon_unstable - u0 !== 0) begin
      errors++;
      $display("FAIL store_hold: reqs=%0d unstable=%0d, required 3 0", mon_reqs - r0, mon_unstable - u0);
    end
    checks++;
    if (mon_we !== 1'b1 || mon_wdata !== 32'hA5A5_0001 || mon_addr !== 30'h40) begin
      errors++;
      $display("FAIL store_bus: we=%b wdata=%h addr=%h, required 1 a5a50001 40", mon_we, mon_wdata, mon_addr);
    end
    checks++;
    if (rd !== exp_rd || bus_mem[0] !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL store_result: rd=%h mem=%h, required %h a5a50001", rd, bus_mem[0], exp_rd);
    end
  endtask

  task automatic test_timeout;
    int st, r0;
    resp_en = 1'b0;
    r0 = mon_reqs;
    do_instr(1'b1, 1'b0, 32'h0000_0040, 32'd0, st);
    exp_rd = 32'hDEAD_BEEF;
    checks++;
    if (st !== 17 || mon_reqs - r0 !== 16) begin
      errors++;
      $display("FAIL timeout_len: stall=%0d reqs=%0d, required 17 16", st, mon_reqs - r0);
    end
    checks++;
    if (err_timeout !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL timeout_result: err=%b rd=%h, required 1 deadbeef", err_timeout, rd);
    end
    err_clear = 1'b1;
    @(posedge clock);
    #1;
    err_clear = 1'b0;
    @(negedge clock);
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b, required 0", err_timeout); end
    @(posedge clock);
    #1;
    resp_en = 1'b1;
  endtask

  task automatic test_misaligned;
    int st, r0;
    r0 = mon_reqs;
    do_instr(1'b1, 1'b0, 32'h0000_0102, 32'd0, st);
    exp_rd = 32'd0;
    checks++;
    if (st !== 1 || mon_reqs - r0 !== 0) begin
      errors++;
      $display("FAIL misaligned_bus: stall=%0d reqs=%0d, required 1 0", st, mon_reqs - r0);
    end
    checks++;
    if (err_misaligned !== 1'b1 || rd !== 32'd0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_result: mis=%b rd=%h to=%b, required 1 0 0", err_misaligned, rd, err_timeout);
    end
  endtask

  task automatic test_reset_mid_access;
    int st;
    ack_delay = 1;
    bus_mem[8] = 32'hCAFE_0001; ref_mem[8] = 32'hCAFE_0001;
    do_instr(1'b1, 1'b0, 32'h0000_0020, 32'd0, st);
    resp_en = 1'b0;
    mem_read = 1'b1; alu_out = 32'h0000_0020;
    idle_cycles(2);
    reset = 1'b0; mem_read = 1'b0;
    idle_cycles(1);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus_req !== 1'b0 || rd !== 32'd0 || stall !== 1'b0 || err_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b rd=%h stall=%b mis=%b, required 0 0 0 0", bus_req, rd, stall, err_misaligned);
    end
    @(posedge clock);
    #1;
    manual_ack = 1'b1;
    idle_cycles(1);
    manual_ack = 1'b0;
    @(negedge clock);
    checks++;
    if (bus_req !== 1'b0 || rd !== 32'd0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL late_ack: req=%b rd=%h to=%b, required 0 0 0", bus_req, rd, err_timeout);
    end
    @(posedge clock);
    #1;
    resp_en = 1'b1; ack_delay = 2;
    do_instr(1'b1, 1'b0, 32'h0000_0020, 32'd0, st);
    exp_rd = ref_mem[8];
    checks++;
    if (st !== 3 || rd !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL after_reset_load: stall=%0d rd=%h, required 3 cafe0001", st, rd);
    end
  endtask

  task automatic test_random;
    int st, kind, w, n;
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      w    = $urandom_range(0, 63);
      n    = $urandom_range(1, 4);
      d    = $urandom;
      ack_delay = n;
      case (kind)
        0, 4: begin
          do_instr(1'b1, kind == 4, 32'(w) << 2, d, st);
          exp_rd = ref_mem[w];
          checks++;
          if (st !== 1 + n || rd !== exp_rd) begin
            errors++;
            $display("FAIL rand_load[%0d]: stall=%0d rd=%h, required %0d %h", i, st, rd, 1 + n, exp_rd);
          end
        end
        1: begin
          do_instr(1'b0, 1'b1, 32'(w) << 2, d, st);
          ref_mem[w] = d;
          checks++;
          if (st !== (POSTED ? 0 : 1 + n) || rd !== exp_rd) begin
            errors++;
            $display("FAIL rand_store[%0d]: stall=%0d rd=%h, required %0d %h", i, st, rd, POSTED ? 0 : 1 + n, exp_rd);
          end
          idle_cycles(n + 1);
        end
        2: begin
          do_instr(1'b0, 1'b0, 32'(w) << 2, d, st);
          checks++;
          if (st !== 0 || rd !== exp_rd) begin
            errors++;
            $display("FAIL rand_nop[%0d]: stall=%0d rd=%h, required 0 %h", i, st, rd, exp_rd);
          end
        end
        default: begin
          if (w[0]) exp_rd = 32'd0;
          do_instr(w[0], ~w[0], (32'(w) << 2) | 32'($urandom_range(1, 3)), d, st);
          checks++;
          if (st !== 1 || rd !== exp_rd || err_misaligned !== 1'b1) begin
            errors++;
            $display("FAIL rand_misaligned[%0d]: stall=%0d rd=%h mis=%b, required 1 %h 1", i, st, rd, err_misaligned, exp_rd);
          end
        end
      endcase
    end
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL rand_no_timeout: got %b, required 0", err_timeout); end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (bus_mem[j] !== ref_mem[j]) begin
        errors++;
        $display("FAIL rand_mem[%0d]: got %h, required %h", j, bus_mem[j], ref_mem[j]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int st_w, st_r;
    ack_delay = 2;
    do_instr(1'b0, 1'b1, 32'h0000_0054, 32'h0BAD_F00D, st_w);
    do_instr(1'b1, 1'b0, 32'h0000_0054, 32'd0, st_r);
    ref_mem[21] = 32'h0BAD_F00D;
    exp_rd = ref_mem[21];
    checks++;
    if (st_w !== (POSTED ? 0 : 3) || st_r !== (POSTED ? 5 : 3)) begin
      errors++;
      $display("FAIL b2b_stall: store=%0d load=%0d, required %0d %0d", st_w, st_r, POSTED ? 0 : 3, POSTED ? 5 : 3);
    end
    checks++;
    if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_rd: got %h, required 0badf00d", rd); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      bus_mem[i] = $urandom;
      ref_mem[i] = bus_mem[i];
    end
    test_reset;
    test_load_immediate;
    test_store_delayed;
    test_timeout;
    test_misaligned;
    test_reset_mid_access;
    test_random;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
